// File: rtl/dmem_mmio_if.sv
// Core-to-data-memory bus: store strobe, byte address and data out; load data and error flag back.
interface dmem_mmio_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        addr_err;

  modport master (output memwrite, addr, writedata, input readdata, addr_err);
  modport slave  (input memwrite, addr, writedata, output readdata, addr_err);
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO page (LED, cycle counter, down-timer with W1C status); combinational reads, writes on the edge.
// No backpressure: every access completes in its own cycle, errors read 0 and drop writes.
module dmem_mmio #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
  input  logic       clk,
  input  logic       reset,
  dmem_mmio_if.slave bus,
  output logic [7:0] leds,
  output logic       irq
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic [7:0]    off;
  logic          misaligned, ram_hit, mmio_hit;

  logic [7:0]  led_q;
  logic [31:0] cycle, tload, tcount, tcount_nxt;
  logic [2:0]  tctrl;
  logic        tstat, tstat_nxt;
  logic        we_led, we_tload, we_tctrl, we_tstat, ram_we;
  logic        en, auto_rl, expiry;

  assign widx       = bus.addr[AW+1:2];
  assign off        = bus.addr[7:0];
  assign misaligned = |bus.addr[1:0];
  assign ram_hit    = !misaligned && (bus.addr < RAM_BYTES);
  assign mmio_hit   = !misaligned && (bus.addr[31:8] == MMIO_BASE[31:8]) && (off <= 8'h14);
  assign bus.addr_err = !(ram_hit || mmio_hit);

  assign ram_we   = bus.memwrite && ram_hit;
  assign we_led   = bus.memwrite && mmio_hit && (off == 8'h00);
  assign we_tload = bus.memwrite && mmio_hit && (off == 8'h08);
  assign we_tctrl = bus.memwrite && mmio_hit && (off == 8'h0C);
  assign we_tstat = bus.memwrite && mmio_hit && (off == 8'h14);

  always_ff @(posedge clk) begin
    if (ram_we) mem[widx] <= bus.writedata;
  end

  always_comb begin
    bus.readdata = 32'h0;
    if (ram_hit) begin
      bus.readdata = mem[widx];
    end else if (mmio_hit) begin
      case (off)
        8'h00:   bus.readdata = {24'h0, led_q};
        8'h04:   bus.readdata = cycle;
        8'h08:   bus.readdata = tload;
        8'h0C:   bus.readdata = {29'h0, tctrl};
        8'h10:   bus.readdata = tcount;
        8'h14:   bus.readdata = {31'h0, tstat};
        default: bus.readdata = 32'h0;
      endcase
    end
  end

  // Timer uses the pre-edge EN/AUTO; a TLOAD write overrides the count but not the expiry flag.
  assign en      = tctrl[0];
  assign auto_rl = tctrl[1];
  assign expiry  = en && (tcount == 32'd1);

  always_comb begin
    tcount_nxt = tcount;
    if (we_tload)
      tcount_nxt = bus.writedata;
    else if (expiry)
      tcount_nxt = auto_rl ? tload : 32'd0;
    else if (en && (tcount != 32'd0))
      tcount_nxt = tcount - 32'd1;
  end

  always_comb begin
    tstat_nxt = tstat;
    if (expiry)
      tstat_nxt = 1'b1;
    else if (we_tstat && bus.writedata[0])
      tstat_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= 8'h0;
      cycle  <= 32'h0;
      tload  <= 32'h0;
      tctrl  <= 3'h0;
      tcount <= 32'h0;
      tstat  <= 1'b0;
    end else begin
      cycle  <= cycle + 32'd1;
      tcount <= tcount_nxt;
      tstat  <= tstat_nxt;
      if (we_led)   led_q <= bus.writedata[7:0];
      if (we_tload) tload <= bus.writedata;
      if (we_tctrl) tctrl <= bus.writedata[2:0];
    end
  end

  assign leds = led_q;
  assign irq  = tstat && tctrl[2];
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, decode errors, cycle counter, timer modes, LED and async reset.
module tb_dmem_mmio;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] leds;
  logic irq;
  int errors = 0;
  int checks = 0;
  logic [31:0] c0, c1;

  localparam logic [31:0] LED  = 32'hFFFF0000;
  localparam logic [31:0] CYC  = 32'hFFFF0004;
  localparam logic [31:0] TLD  = 32'hFFFF0008;
  localparam logic [31:0] TCT  = 32'hFFFF000C;
  localparam logic [31:0] TCNT = 32'hFFFF0010;
  localparam logic [31:0] TST  = 32'hFFFF0014;

  dmem_mmio_if bus();

  dmem_mmio #(.DEPTH(64), .MMIO_BASE(32'hFFFF0000)) dut (
    .clk(clk), .reset(reset), .bus(bus), .leds(leds), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Each cycle: inputs driven at edge+1, sampled a few ns later, well before the next edge.
  task automatic tick();
    @(posedge clk); #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.memwrite = 1'b0; bus.addr = a; bus.writedata = 32'h0; #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite = 1'b1; bus.addr = a; bus.writedata = d; #1;
  endtask

  task automatic test_reset();
    rd(CYC);  checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_cycle: got %h want 0", bus.readdata); end
    checks++; if (leds !== 8'h0) begin errors++; $display("FAIL reset_leds: got %h want 0", leds); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    rd(TCNT); checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_tcount: got %h want 0", bus.readdata); end
    rd(TST);  checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_tstat: got %h want 0", bus.readdata); end
  endtask

  task automatic test_cycle();
    rd(CYC); c0 = bus.readdata;
    checks++; if (c0 !== 32'h0) begin errors++; $display("FAIL cycle_start: got %h want 0", c0); end
    repeat (4) tick();
    rd(CYC); checks++; if (bus.readdata !== c0 + 32'd4) begin errors++; $display("FAIL cycle_plus4: got %h want %h", bus.readdata, c0 + 32'd4); end
    wr(CYC, 32'hDEADBEEF); c1 = bus.readdata;
    tick();
    rd(CYC); checks++; if (bus.readdata !== c1 + 32'd1) begin errors++; $display("FAIL cycle_ro: got %h want %h", bus.readdata, c1 + 32'd1); end
  endtask

  task automatic test_ram();
    wr(32'h10, 32'h12345678); tick();
    rd(32'h10); checks++; if (bus.readdata !== 32'h12345678) begin errors++; $display("FAIL ram_rw: got %h want 12345678", bus.readdata); end
    wr(32'h10, 32'hCAFEF00D);
    checks++; if (bus.readdata !== 32'h12345678) begin errors++; $display("FAIL ram_old_on_write: got %h want 12345678", bus.readdata); end
    tick();
    rd(32'h10); checks++; if (bus.readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ram_overwrite: got %h want cafef00d", bus.readdata); end
    wr(32'h11, 32'hFFFFFFFF);
    checks++; if (bus.addr_err !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b want 1", bus.addr_err); end
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL misaligned_rd: got %h want 0", bus.readdata); end
    tick();
    rd(32'h10); checks++; if (bus.readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL misaligned_nowrite: got %h want cafef00d", bus.readdata); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL ram_err: got %b want 0", bus.addr_err); end
    rd(32'd256); checks++; if (bus.readdata !== 32'h0 || bus.addr_err !== 1'b1) begin errors++; $display("FAIL ram_oob: got %h/%b want 0/1", bus.readdata, bus.addr_err); end
    rd(32'd252); checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL ram_last: got %b want 0", bus.addr_err); end
    rd(32'hFFFF0018); checks++; if (bus.addr_err !== 1'b1) begin errors++; $display("FAIL mmio_hole: got %b want 1", bus.addr_err); end
    rd(32'hFFFE0000); checks++; if (bus.addr_err !== 1'b1) begin errors++; $display("FAIL unmapped: got %b want 1", bus.addr_err); end
    wr(32'hFFFF0002, 32'hFF); tick();
    checks++; if (leds !== 8'h0) begin errors++; $display("FAIL led_misaligned: got %h want 0", leds); end
  endtask

  task automatic test_oneshot();
    wr(TLD, 32'd3); tick();
    wr(TCT, 32'h5); tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd3) begin errors++; $display("FAIL os_cnt3: got %h want 3", bus.readdata); end
    tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd2) begin errors++; $display("FAIL os_cnt2: got %h want 2", bus.readdata); end
    tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL os_cnt1: got %h want 1", bus.readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq_early: got %b want 0", irq); end
    tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL os_cnt0: got %h want 0", bus.readdata); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL os_irq: got %b want 1", irq); end
    rd(TST); checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL os_tstat: got %h want 1", bus.readdata); end
    tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL os_hold0: got %h want 0", bus.readdata); end
    wr(TST, 32'd1); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_w1c_irq: got %b want 0", irq); end
    rd(TST); checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL os_w1c: got %h want 0", bus.readdata); end
    wr(TCT, 32'h0); tick();
  endtask

  task automatic test_auto();
    wr(TLD, 32'd2); tick();
    wr(TCT, 32'h7); tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd2) begin errors++; $display("FAIL ar_old_en: got %h want 2", bus.readdata); end
    tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL ar_cnt1: got %h want 1", bus.readdata); end
    tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd2) begin errors++; $display("FAIL ar_reload: got %h want 2", bus.readdata); end
    rd(TST); checks++; if (bus.readdata !== 32'd1 || irq !== 1'b1) begin errors++; $display("FAIL ar_tstat: got %h/%b want 1/1", bus.readdata, irq); end
    wr(TST, 32'd1); tick();
    rd(TST); checks++; if (bus.readdata !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL ar_w1c: got %h/%b want 0/0", bus.readdata, irq); end
    rd(TCNT); checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL ar_cnt1b: got %h want 1", bus.readdata); end
    wr(TST, 32'd1); tick();
    rd(TST); checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL ar_set_wins: got %h want 1", bus.readdata); end
    rd(TCNT); checks++; if (bus.readdata !== 32'd2) begin errors++; $display("FAIL ar_reload2: got %h want 2", bus.readdata); end
    wr(TCT, 32'h0); tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL ar_dis_old_en: got %h want 1", bus.readdata); end
    tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL ar_dis_hold: got %h want 1", bus.readdata); end
    wr(TST, 32'd1); tick();
  endtask

  task automatic test_tload_on_expiry();
    wr(TLD, 32'd1); tick();
    wr(TCT, 32'h1); tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL le_pre: got %h want 1", bus.readdata); end
    wr(TLD, 32'd9); tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd9) begin errors++; $display("FAIL le_cnt: got %h want 9", bus.readdata); end
    rd(TST); checks++; if (bus.readdata !== 32'd1) begin errors++; $display("FAIL le_tstat: got %h want 1", bus.readdata); end
    tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd8) begin errors++; $display("FAIL le_next: got %h want 8", bus.readdata); end
  endtask

  task automatic test_led_reset();
    wr(LED, 32'h1A5); tick();
    checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL led_out: got %h want a5", leds); end
    rd(LED); checks++; if (bus.readdata !== 32'h000000A5) begin errors++; $display("FAIL led_rd: got %h want a5", bus.readdata); end
    wr(TLD, 32'd50); tick();
    wr(TCT, 32'h5); tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq: got %b want 1", irq); end
    tick();
    rd(TCNT); checks++; if (bus.readdata !== 32'd48) begin errors++; $display("FAIL pre_rst_cnt: got %h want 48", bus.readdata); end
    reset = 1'b0; #1;
    checks++; if (leds !== 8'h0 || irq !== 1'b0) begin errors++; $display("FAIL async_rst_out: got %h/%b want 0/0", leds, irq); end
    rd(TCNT); checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL async_rst_cnt: got %h want 0", bus.readdata); end
    rd(CYC); checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL async_rst_cyc: got %h want 0", bus.readdata); end
    tick();
    reset = 1'b1;
    rd(32'h10); checks++; if (bus.readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ram_kept: got %h want cafef00d", bus.readdata); end
    rd(CYC); checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL cyc_after_rst: got %h want 0", bus.readdata); end
  endtask

  initial begin
    reset = 1'b0;
    bus.memwrite = 1'b0; bus.addr = 32'h0; bus.writedata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    reset = 1'b1;
    test_cycle();
    test_ram();
    test_oneshot();
    test_auto();
    test_tload_on_expiry();
    test_led_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory stage directly downstream of the single-cycle MIPS core.
- Consumes the core's memwrite, ALU result (byte address) and writedata; returns readdata in the same cycle.
- Maps a word-addressed data RAM plus a small MMIO page: LED register, free-running cycle counter, and a down-counting timer with a W1C interrupt status.
- Drives the board LEDs and a level interrupt line.

Parameters:
- DEPTH, 64, number of 32-bit RAM words; power of two, 2..1024.
- MMIO_BASE, 32'hFFFF0000, base byte address of the MMIO page; low 8 bits must be zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all registers immediately.
- memwrite  in  1  store strobe from the core, valid for the current cycle.
- addr  in  32  byte address (core ALU result).
- writedata  in  32  store data.
- readdata  out  32  load data; combinational from addr and current register state.
- leds  out  8  LED register contents.
- irq  out  1  timer interrupt; level-sensitive.
- addr_err  out  1  combinational flag: current access is misaligned or unmapped.

Behaviour:
- Decode (combinational):
  - addr[1:0]!=0 → misaligned.
  - addr < 4*DEPTH → RAM, word index addr[log2(DEPTH)+1:2].
  - addr[31:8]==MMIO_BASE[31:8] and addr[7:0] in {00,04,08,0C,10,14} → MMIO.
  - Anything else → unmapped.
- addr_err=1 for misaligned or unmapped, regardless of memwrite. Reads of error addresses return 0; writes to them are dropped with no side effects.
- RAM:
  - Synchronous write when memwrite and RAM hit.
  - Asynchronous read of the addressed word; a read in the same cycle as a write to that word returns the old value.
  - Contents are not reset.
- MMIO registers (offset, access, reset value):
  - 0x00 LED, RW, bits [7:0], 0. Reads zero-extend. Writes take writedata[7:0].
  - 0x04 CYCLE, RO, 0. Increments every cycle out of reset; wraps 0xFFFFFFFF→0. Writes ignored.
  - 0x08 TLOAD, RW, 0. Writing it also copies writedata into TCOUNT on the same edge.
  - 0x0C TCTRL, RW, 0. Bit0 EN, bit1 AUTO, bit2 IE. Bits [31:3] read 0.
  - 0x10 TCOUNT, RO, 0. Writes ignored.
  - 0x14 TSTAT, bit0 only, 0. Writing 1 to bit0 clears it; writing 0 has no effect.
- Timer, evaluated per edge:
  - If EN=1 and TCOUNT!=0: TCOUNT decrements.
  - When TCOUNT==1 with EN=1 (expiry): TSTAT is set.
    - AUTO=1: TCOUNT takes TLOAD instead of 0.
    - AUTO=0: TCOUNT stops at 0.
  - TCOUNT==0 with EN=1: no change, no new expiry.
  - EN=0: TCOUNT holds.
- irq = TSTAT & IE. Registered state, so there are no combinational paths from inputs to irq.
- Simultaneous events:
  - TLOAD write and expiry on the same edge: TCOUNT takes the written value, and TSTAT is still set.
  - TSTAT W1C and expiry on the same edge: set wins, TSTAT stays 1.
  - TCTRL write and decrement on the same edge: the decrement uses the old EN; the new EN applies from the next edge.
- Latency:
  - Writes are visible on readdata the cycle after the edge.
  - MMIO reads return pre-edge register values.
  - irq rises one cycle after the expiry edge's inputs (i.e. on that edge).
- Reset mid-operation: all MMIO registers, leds and irq go to 0 asynchronously while reset=0. CYCLE restarts at 0 on the first edge after release. RAM is untouched.

Test Plan:
- After reset release, read 0x04 at cycles 1 and 5 → values differ by 4. Write 0xDEADBEEF to 0x04 → no effect on counting.
- Store 0x12345678 to addr 0x10, load 0x10 next cycle → 0x12345678. Store to 0x11 → addr_err=1, word 0x10 unchanged. Load 4*DEPTH → readdata=0, addr_err=1.
- Write TLOAD=3, TCTRL=0x5 → TCOUNT reads 3,2,1,0. TSTAT=1 and irq=1 on the edge where TCOUNT 1→0. TCOUNT holds 0 after that. Write TSTAT=1 → irq=0 next cycle.
- TLOAD=2, TCTRL=0x7 → TCOUNT sequence 2,1,2,1,2…; TSTAT set on each reload. W1C issued in an expiry cycle → TSTAT remains 1.
- Write LED=0x1A5 → leds=0xA5, read 0x00 → 0x000000A5. Pull reset low asynchronously mid-count → leds, irq and TCOUNT are 0 before the next clk edge. Previously written RAM word still reads back.
- Write TLOAD=9 on the exact expiry edge (TCOUNT=1, EN=1, AUTO=0) → TCOUNT=9 and TSTAT=1.
